// File: rtl/frame_buffer_arbiter.sv
// Arbitrates one single-port, double-banked pixel RAM between the display read path and the
// compute engine. Bank swaps are deferred until the display is idle and compute is quiet.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// NORMAL  | no swap outstanding
// PENDING | swap requested, waiting for display idle and no compute request
module frame_buffer_arbiter #(
   parameter int ADDR_W   = 6,
   parameter int DATA_W   = 24,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              disp_gnt,
   output logic              disp_rvalid,
   output logic [DATA_W-1:0] disp_rdata,
   input  logic              disp_frame_active,
   input  logic              calc_req,
   input  logic              calc_we,
   input  logic [ADDR_W-1:0] calc_addr,
   input  logic [DATA_W-1:0] calc_wdata,
   output logic              calc_gnt,
   output logic              calc_rvalid,
   output logic [DATA_W-1:0] calc_rdata,
   input  logic              swap_req,
   output logic              swap_ack,
   output logic              front_bank,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W:0]   mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int WCNT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic {NORMAL, PENDING} swap_state_t;

   swap_state_t       state_q;
   logic              front_bank_q;
   logic              swap_ack_q;
   logic              disp_rvalid_q;
   logic              calc_rvalid_q;
   logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              calc_prio;

   assign calc_prio = (wait_cnt_q == WCNT_W'(MAX_WAIT));

   // Display wins by default; a starved compute request takes one slot.
   always_comb begin
      disp_gnt = 1'b0;
      calc_gnt = 1'b0;
      if (!rst) begin
         if (calc_req && (calc_prio || !disp_req)) begin
            calc_gnt = 1'b1;
         end else if (disp_req) begin
            disp_gnt = 1'b1;
         end
      end
   end

   assign mem_en    = disp_gnt | calc_gnt;
   assign mem_we    = calc_gnt & calc_we;
   assign mem_addr  = calc_gnt ? {~front_bank_q, calc_addr} : {front_bank_q, disp_addr};
   assign mem_wdata = calc_wdata;

   always_comb begin
      wait_cnt_d = '0;
      if (calc_req && !calc_gnt) begin
         wait_cnt_d = calc_prio ? wait_cnt_q : wait_cnt_q + WCNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt_q    <= '0;
         disp_rvalid_q <= 1'b0;
         calc_rvalid_q <= 1'b0;
      end else begin
         wait_cnt_q    <= wait_cnt_d;
         disp_rvalid_q <= disp_gnt;
         calc_rvalid_q <= calc_gnt & ~calc_we;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= NORMAL;
         front_bank_q <= 1'b0;
         swap_ack_q   <= 1'b0;
      end else begin
         swap_ack_q <= 1'b0;
         case (state_q)
            NORMAL: begin
               if (swap_req) state_q <= PENDING;
            end
            PENDING: begin
               if (!disp_frame_active && !calc_req) begin
                  front_bank_q <= ~front_bank_q;
                  swap_ack_q   <= 1'b1;
                  state_q      <= NORMAL;
               end
            end
         endcase
      end
   end

   // Read returns issued just before a reset are suppressed while reset is held.
   assign disp_rvalid = disp_rvalid_q & ~rst;
   assign calc_rvalid = calc_rvalid_q & ~rst;
   assign disp_rdata  = mem_rdata;
   assign calc_rdata  = mem_rdata;
   assign swap_ack    = swap_ack_q & ~rst;
   assign front_bank  = front_bank_q;

endmodule
